// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one transaction at a time.
// Define MEM_ARB_FAIR_EN for alternating priority; otherwise data requests always beat fetches.
module mem_port_arbiter #(
   parameter int XLEN = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [XLEN-1:0]   if_addr,
   input  logic              if_kill,
   output logic              if_rsp_valid,
   output logic [31:0]       if_rdata,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [XLEN-1:0]   dm_addr,
   input  logic [XLEN-1:0]   dm_wdata,
   input  logic [XLEN/8-1:0] dm_wstrb,
   output logic              dm_rsp_valid,
   output logic [XLEN-1:0]   dm_rdata,
   output logic              stall_if,
   output logic              stall_mem,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic              mem_we,
   output logic [XLEN-1:0]   mem_addr,
   output logic [XLEN-1:0]   mem_wdata,
   output logic [XLEN/8-1:0] mem_wstrb,
   input  logic              mem_rsp_valid,
   input  logic [XLEN-1:0]   mem_rdata
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
   typedef enum logic {OWN_FETCH, OWN_DATA} owner_t;

   state_t              state_q, state_d;
   owner_t              owner_q, owner_d;
   logic                killed_q, killed_d;
   logic                we_q, we_d;
   logic [XLEN-1:0]     addr_q, addr_d;
   logic [XLEN-1:0]     wdata_q, wdata_d;
   logic [XLEN/8-1:0]   wstrb_q, wstrb_d;
   logic                half_q, half_d;
   logic [XLEN-1:0]     rdata_q, rdata_d;

   logic                fetch_ok;
   logic                pick_data;
   logic                pick_fetch;
   logic                resp_fire;
   logic                unused_addr_bits;

   assign unused_addr_bits = ^if_addr[1:0];

   always_comb begin
      fetch_ok = if_req & ~if_kill;
`ifdef MEM_ARB_FAIR_EN
      // owner_q still names the previous grant while idle, so it doubles as the priority token
      pick_data = dm_req & (~fetch_ok | (owner_q == OWN_FETCH));
`else
      pick_data = dm_req;
`endif
      pick_fetch = fetch_ok & ~pick_data;
   end

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      killed_d = killed_q;
      we_d     = we_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      wstrb_d  = wstrb_q;
      half_d   = half_q;
      rdata_d  = rdata_q;

      case (state_q)
         S_IDLE: begin
            if (pick_data) begin
               owner_d = OWN_DATA;
               we_d    = dm_we;
               addr_d  = dm_addr;
               wdata_d = dm_wdata;
               wstrb_d = dm_wstrb;
               state_d = S_ISSUE;
            end else if (pick_fetch) begin
               owner_d = OWN_FETCH;
               we_d    = 1'b0;
               addr_d  = {if_addr[XLEN-1:3], 3'b000};
               wdata_d = '0;
               wstrb_d = '0;
               half_d  = if_addr[2];
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (mem_req_ready) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (mem_rsp_valid) begin
               rdata_d = mem_rdata;
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            // The requester still holds its finished request this cycle, so nothing is sampled here
            killed_d = 1'b0;
            state_d  = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (if_kill && (owner_q == OWN_FETCH) &&
          ((state_q == S_ISSUE) || (state_q == S_WAIT))) begin
         killed_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         owner_q  <= OWN_FETCH;
         killed_q <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         wstrb_q  <= '0;
         half_q   <= 1'b0;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         killed_q <= killed_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         wstrb_q  <= wstrb_d;
         half_q   <= half_d;
         rdata_q  <= rdata_d;
      end
   end

   // A kill arriving in the response cycle itself must still swallow the fetch data
   assign resp_fire     = (state_q == S_RESP) & ~reset;
   assign if_rsp_valid  = resp_fire & (owner_q == OWN_FETCH) & ~killed_q & ~if_kill;
   assign dm_rsp_valid  = resp_fire & (owner_q == OWN_DATA);
   assign if_rdata      = half_q ? rdata_q[32 +: 32] : rdata_q[0 +: 32];
   assign dm_rdata      = rdata_q;

   assign mem_req_valid = (state_q == S_ISSUE) & ~reset;
   assign mem_we        = we_q;
   assign mem_addr      = addr_q;
   assign mem_wdata     = wdata_q;
   assign mem_wstrb     = wstrb_q;

   assign stall_if      = if_req & ~if_rsp_valid & ~if_kill;
   assign stall_mem     = dm_req & ~dm_rsp_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: table of single transactions plus hand-written
// sequences for contention, kill, reset mid-transaction and back-to-back loads.
module tb_mem_port_arbiter;

   localparam logic [63:0] JUNK = 64'hDEAD_DEAD_DEAD_DEAD;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_req, if_kill;
   logic [63:0] if_addr;
   logic        if_rsp_valid;
   logic [31:0] if_rdata;
   logic        dm_req, dm_we;
   logic [63:0] dm_addr, dm_wdata;
   logic [7:0]  dm_wstrb;
   logic        dm_rsp_valid;
   logic [63:0] dm_rdata;
   logic        stall_if, stall_mem;
   logic        mem_req_valid, mem_req_ready, mem_we;
   logic [63:0] mem_addr, mem_wdata;
   logic [7:0]  mem_wstrb;
   logic        mem_rsp_valid;
   logic [63:0] mem_rdata;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.XLEN(64)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
      .if_rsp_valid(if_rsp_valid), .if_rdata(if_rdata),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_wstrb(dm_wstrb), .dm_rsp_valid(dm_rsp_valid), .dm_rdata(dm_rdata),
      .stall_if(stall_if), .stall_mem(stall_mem),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata)
   );

   typedef struct {
      logic        is_data;
      logic        we;
      logic [63:0] addr;
      logic [63:0] wdata;
      logic [7:0]  wstrb;
      logic [63:0] rdata;
      int          rdy_dly;
      int          rsp_dly;
      logic [63:0] exp_addr;
      logic        exp_we;
      logic [7:0]  exp_wstrb;
      logic [63:0] exp_rdata;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic at_neg();
      @(negedge clk);
   endtask

   task automatic clear_req();
      if_req = 1'b0; if_addr = '0; if_kill = 1'b0;
      dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0; dm_wstrb = '0;
   endtask

   task automatic set_fetch(input logic [63:0] a);
      if_req = 1'b1; if_addr = a;
   endtask

   task automatic set_load(input logic [63:0] a);
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = a; dm_wdata = '0; dm_wstrb = '0;
   endtask

   // Called in the ISSUE cycle after sampling; leaves the DUT at the start of RESP
   task automatic serve(input logic [63:0] data);
      mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b1;
      mem_rdata     = data;
      step();
      mem_rsp_valid = 1'b0;
      mem_rdata     = JUNK;
   endtask

   function automatic logic [63:0] mem_word(input logic [63:0] a);
      return {a[31:0], ~a[31:0]};
   endfunction

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic        first_data;
      logic [63:0] first_addr, second_addr;
      logic [63:0] b2b_addr, resp_data;
      logic        resp_pending, accept;
      int          hs, rsps, extra;

      vecs[0] = '{1'b0, 1'b0, 64'h104,  64'h0, 8'h00, 64'hAAAA_BBBB_CCCC_DDDD, 0, 0,
                  64'h100,  1'b0, 8'h00, 64'h0000_0000_AAAA_BBBB};
      vecs[1] = '{1'b0, 1'b0, 64'h200,  64'h0, 8'h00, 64'h1111_2222_3333_4444, 1, 2,
                  64'h200,  1'b0, 8'h00, 64'h0000_0000_3333_4444};
      vecs[2] = '{1'b1, 1'b0, 64'h2000, 64'h0, 8'h00, 64'h0123_4567_89AB_CDEF, 0, 0,
                  64'h2000, 1'b0, 8'h00, 64'h0123_4567_89AB_CDEF};
      vecs[3] = '{1'b1, 1'b1, 64'h3008, 64'hDEAD_BEEF_0000_0000, 8'hF0, 64'h0, 4, 0,
                  64'h3008, 1'b1, 8'hF0, 64'h0};
      vecs[4] = '{1'b1, 1'b0, 64'h2003, 64'h0, 8'h00, 64'hFEDC_BA98_7654_3210, 0, 1,
                  64'h2003, 1'b0, 8'h00, 64'hFEDC_BA98_7654_3210};
      vecs[5] = '{1'b0, 1'b0, 64'h7FFC, 64'h0, 8'h00, 64'h89AB_CDEF_0123_4567, 2, 0,
                  64'h7FF8, 1'b0, 8'h00, 64'h0000_0000_89AB_CDEF};

      reset = 1'b1;
      clear_req();
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = JUNK;
      step(); step();
      at_neg();
      chk("rst_mem_req_valid", mem_req_valid, 0);
      chk("rst_if_rsp_valid", if_rsp_valid, 0);
      chk("rst_dm_rsp_valid", dm_rsp_valid, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_stall_if", stall_if, 0);
      dm_req = 1'b1;
      #1;
      chk("rst_stall_mem_eq", stall_mem, 1);
      step();
      reset = 1'b0;
      clear_req();
      step();

      // ---- table-driven single transactions ----
      for (int i = 0; i < 6; i++) begin
         if (vecs[i].is_data) begin
            dm_req = 1'b1; dm_we = vecs[i].we; dm_addr = vecs[i].addr;
            dm_wdata = vecs[i].wdata; dm_wstrb = vecs[i].wstrb;
         end else begin
            set_fetch(vecs[i].addr);
         end
         at_neg();
         chk($sformatf("v%0d_stall_req", i), vecs[i].is_data ? stall_mem : stall_if, 1);
         chk($sformatf("v%0d_idle_valid", i), mem_req_valid, 0);
         step();
         for (int k = 0; k <= vecs[i].rdy_dly; k++) begin
            mem_req_ready = (k == vecs[i].rdy_dly);
            at_neg();
            chk($sformatf("v%0d_req_valid", i), mem_req_valid, 1);
            chk($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].exp_addr);
            chk($sformatf("v%0d_mem_we", i), mem_we, vecs[i].exp_we);
            chk($sformatf("v%0d_mem_wstrb", i), mem_wstrb, vecs[i].exp_wstrb);
            if (vecs[i].is_data)
               chk($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].wdata);
            step();
         end
         mem_req_ready = 1'b0;
         for (int k = 0; k <= vecs[i].rsp_dly; k++) begin
            mem_rsp_valid = (k == vecs[i].rsp_dly);
            mem_rdata = (k == vecs[i].rsp_dly) ? vecs[i].rdata : JUNK;
            at_neg();
            chk($sformatf("v%0d_wait_valid", i), mem_req_valid, 0);
            chk($sformatf("v%0d_early_rsp", i), {if_rsp_valid, dm_rsp_valid}, 0);
            step();
         end
         mem_rsp_valid = 1'b0;
         mem_rdata = JUNK;
         at_neg();
         if (vecs[i].is_data) begin
            chk($sformatf("v%0d_dm_rsp", i), dm_rsp_valid, 1);
            chk($sformatf("v%0d_if_rsp", i), if_rsp_valid, 0);
            if (!vecs[i].we) chk($sformatf("v%0d_dm_rdata", i), dm_rdata, vecs[i].exp_rdata);
            chk($sformatf("v%0d_stall_mem", i), stall_mem, 0);
         end else begin
            chk($sformatf("v%0d_if_rsp", i), if_rsp_valid, 1);
            chk($sformatf("v%0d_dm_rsp", i), dm_rsp_valid, 0);
            chk($sformatf("v%0d_if_rdata", i), {32'h0, if_rdata}, vecs[i].exp_rdata);
            chk($sformatf("v%0d_stall_if", i), stall_if, 0);
         end
         step();
         clear_req();
         at_neg();
         chk($sformatf("v%0d_rsp_once", i), {if_rsp_valid, dm_rsp_valid}, 0);
         chk($sformatf("v%0d_no_reissue", i), mem_req_valid, 0);
         $display("txn vec %0d: %s addr %h done", i, vecs[i].is_data ? "data" : "fetch", vecs[i].addr);
         step();
      end

      // ---- contention after a fetch grant: data first in either mode ----
      set_fetch(64'h400);
      set_load(64'h2000);
      at_neg();
      chk("ct_stall_if", stall_if, 1);
      chk("ct_stall_mem", stall_mem, 1);
      step();
      at_neg();
      chk("ct_first_addr", mem_addr, 64'h2000);
      serve(64'h5A5A_0000_1234_5678);
      at_neg();
      chk("ct_dm_rsp", dm_rsp_valid, 1);
      chk("ct_if_rsp", if_rsp_valid, 0);
      chk("ct_dm_rdata", dm_rdata, 64'h5A5A_0000_1234_5678);
      chk("ct_stall_if_held", stall_if, 1);
      step();
      dm_req = 1'b0;
      at_neg();
      chk("ct_bubble", mem_req_valid, 0);
      step();
      at_neg();
      chk("ct_second_valid", mem_req_valid, 1);
      chk("ct_second_addr", mem_addr, 64'h400);
      serve(64'hCAFE_F00D_1234_5678);
      at_neg();
      chk("ct_if_rsp2", if_rsp_valid, 1);
      chk("ct_if_rdata2", {32'h0, if_rdata}, 64'h1234_5678);
      $display("txn contention: data 0x2000 then fetch 0x400");
      step();
      clear_req();
      step();

      // ---- contention after a data grant: fairness decides ----
      set_load(64'h2040);
      step();
      at_neg();
      serve(64'h1);
      at_neg();
      chk("fa_prior_dm_rsp", dm_rsp_valid, 1);
      step();
      clear_req();
      step();
`ifdef MEM_ARB_FAIR_EN
      first_data = 1'b0;
`else
      first_data = 1'b1;
`endif
      first_addr  = first_data ? 64'h2080 : 64'h480;
      second_addr = first_data ? 64'h480 : 64'h2080;
      set_fetch(64'h484);
      set_load(64'h2080);
      step();
      at_neg();
      chk("fa_first_addr", mem_addr, first_addr);
      serve(64'h7777_6666_5555_4444);
      at_neg();
      chk("fa_first_rsp", first_data ? dm_rsp_valid : if_rsp_valid, 1);
      chk("fa_first_other", first_data ? if_rsp_valid : dm_rsp_valid, 0);
      step();
      if (first_data) dm_req = 1'b0; else if_req = 1'b0;
      at_neg();
      step();
      at_neg();
      chk("fa_second_addr", mem_addr, second_addr);
      serve(64'h7777_6666_5555_4444);
      at_neg();
      chk("fa_second_rsp", first_data ? if_rsp_valid : dm_rsp_valid, 1);
      if (!first_data) chk("fa_dm_rdata", dm_rdata, 64'h7777_6666_5555_4444);
      else chk("fa_if_rdata", {32'h0, if_rdata}, 64'h7777_6666);
      $display("txn fairness: first %h second %h", first_addr, second_addr);
      step();
      clear_req();
      step();

      // ---- kill: in IDLE blocks selection, in WAIT suppresses the response ----
      set_fetch(64'h500);
      if_kill = 1'b1;
      at_neg();
      chk("kl_stall_if_kill", stall_if, 0);
      step();
      if_kill = 1'b0;
      at_neg();
      chk("kl_idle_blocked", mem_req_valid, 0);
      step();
      at_neg();
      chk("kl_issue_addr", mem_addr, 64'h500);
      mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0;
      if_kill = 1'b1;
      if_addr = 64'h600;
      at_neg();
      chk("kl_wait_stall", stall_if, 0);
      step();
      if_kill = 1'b0;
      mem_rsp_valid = 1'b1;
      mem_rdata = 64'h1111_1111_1111_1111;
      at_neg();
      chk("kl_wait_rsp", if_rsp_valid, 0);
      step();
      mem_rsp_valid = 1'b0;
      mem_rdata = JUNK;
      at_neg();
      chk("kl_resp_suppressed", if_rsp_valid, 0);
      chk("kl_resp_stall", stall_if, 1);
      step();
      at_neg();
      chk("kl_drain_idle", mem_req_valid, 0);
      step();
      at_neg();
      chk("kl_new_valid", mem_req_valid, 1);
      chk("kl_new_addr", mem_addr, 64'h600);
      serve(64'h0BAD_0BAD_600D_600D);
      at_neg();
      chk("kl_new_rsp", if_rsp_valid, 1);
      chk("kl_new_rdata", {32'h0, if_rdata}, 64'h600D_600D);
      $display("txn kill: fetch 0x500 killed, fetch 0x600 completed");
      step();
      clear_req();
      step();

      // ---- reset in WAIT ----
      set_load(64'h2100);
      step();
      mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0;
      reset = 1'b1;
      clear_req();
      at_neg();
      chk("rw_during_dm_rsp", dm_rsp_valid, 0);
      step();
      reset = 1'b0;
      at_neg();
      chk("rw_after_valid", mem_req_valid, 0);
      chk("rw_after_addr", mem_addr, 0);
      chk("rw_after_dm_rsp", dm_rsp_valid, 0);
      mem_rsp_valid = 1'b1;
      step();
      mem_rsp_valid = 1'b0;
      at_neg();
      chk("rw_stray_dm_rsp", dm_rsp_valid, 0);
      chk("rw_stray_if_rsp", if_rsp_valid, 0);
      chk("rw_stray_valid", mem_req_valid, 0);
      step();
      set_load(64'h2200);
      step();
      at_neg();
      chk("rw_fresh_addr", mem_addr, 64'h2200);
      serve(64'h2222_3333_4444_5555);
      at_neg();
      chk("rw_fresh_rsp", dm_rsp_valid, 1);
      chk("rw_fresh_rdata", dm_rdata, 64'h2222_3333_4444_5555);
      $display("txn reset: mid-WAIT reset, then load 0x2200 completed");
      step();
      clear_req();
      step();

      // ---- back-to-back loads with dm_req held continuously ----
      b2b_addr = 64'h2300;
      set_load(b2b_addr);
      mem_req_ready = 1'b1;
      resp_pending = 1'b0;
      resp_data = JUNK;
      hs = 0;
      rsps = 0;
      for (int c = 0; c < 40 && rsps < 2; c++) begin
         mem_rsp_valid = resp_pending;
         mem_rdata = resp_pending ? resp_data : JUNK;
         at_neg();
         accept = mem_req_valid & mem_req_ready;
         if (accept) begin
            hs++;
            resp_data = mem_word(mem_addr);
         end
         if (dm_rsp_valid) begin
            chk($sformatf("bb_rdata%0d", rsps), dm_rdata, mem_word(b2b_addr));
            rsps++;
         end
         step();
         resp_pending = accept;
         if (dm_rsp_valid === 1'b0 && rsps == 1 && b2b_addr == 64'h2300) begin
            b2b_addr = 64'h2308;
            dm_addr = b2b_addr;
         end
         if (rsps == 2) dm_req = 1'b0;
      end
      mem_rsp_valid = 1'b0;
      chk("bb_responses", rsps, 2);
      chk("bb_handshakes", hs, 2);
      extra = 0;
      for (int c = 0; c < 4; c++) begin
         at_neg();
         if (mem_req_valid) extra++;
         step();
      end
      chk("bb_no_extra_issue", extra, 0);
      mem_req_ready = 1'b0;
      $display("txn back-to-back: %0d handshakes, %0d responses", hs, rsps);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
